usb_data_rx: RTL and testbench
==============================

USB_DATA_RX -- requirements
Module: usb_data_rx

Interface
REQ-001 useClk  in  1  single system clock; all state updates on rising edge.
REQ-002 resetN  in  1  asynchronous, active-low reset.
REQ-003 checkData  in  1  bit-time strobe, one useClk cycle per USB bit; the block samples inputs only when checkData=1.
REQ-004 rxBit  in  1  NRZI-decoded, bit-destuffed line bit, LSB-first as on the wire.
REQ-005 eopIn  in  1  high while SE0 (EOP) is present on the bus.
REQ-006 pidOut  out  4  PID[3:0] of the last packet with a valid PID; holds until the next valid PID.
REQ-007 pidValid  out  1  one-cycle pulse when a PID passes its check.
REQ-008 dataByte  out  8  last assembled byte, CRC bytes included.
REQ-009 dataValid  out  1  one-cycle pulse per assembled byte.
REQ-010 byteCount  out  7  bytes received in the current DATA packet, CRC bytes included.
REQ-011 packetDone  out  1  one-cycle pulse at end of any packet.
REQ-012 crcOk  out  1  valid with packetDone; 1 = DATA packet with good CRC16.
REQ-013 packetError  out  1  valid with packetDone; 1 = PID check fail, partial byte, overflow, or CRC fail.
REQ-014 busyRx  out  1  high in every state except IDLE.

Function
REQ-015 The block SHALL run states IDLE, PID, DATA, WAIT_EOP; transitions occur only on checkData=1 cycles.
REQ-016 IDLE: shift rxBit into an 8-bit hunt register (new bit at MSB, shift right); on hunt register = 8'h80 (SYNC), go to PID and clear bit counter.
REQ-017 PID: collect 8 bits LSB-first; on the 8th bit, check PID[3:0] == ~PID[7:4].
REQ-018 PID check fail -> packetError latched, go to WAIT_EOP.
REQ-019 PID pass -> pidOut updated, pidValid pulse on the same edge as the 8th bit.
REQ-020 PID pass with PID[3:0] = 4'h3 (DATA0) or 4'hB (DATA1) -> go to DATA; clear byteCount; load CRC register with 16'hFFFF.
REQ-021 PID pass with any other PID -> go to WAIT_EOP; crcOk=0, packetError=0 at packetDone.
REQ-022 DATA: every bit updates the CRC register: x = crc[0]^rxBit; crc = {1'b0, crc[15:1]} ^ (x ? 16'hA001 : 0).
REQ-023 DATA: each byte is assembled LSB-first. On its 8th bit, dataByte is loaded and dataValid pulses on that same edge; byteCount increments, saturating at 67.
REQ-024 A 67th byte (more than 64 payload + 2 CRC) SHALL set overflow, latch packetError, and go to WAIT_EOP.
REQ-025 DATA: if eopIn=1 on a checkData cycle, packet end is evaluated on that edge:
  - crcOk = (crc == 16'hB001) and bitCnt == 0 and byteCount >= 2;
  - packetError = !crcOk;
  - packetDone pulses;
  - next state is IDLE.
REQ-026 WAIT_EOP: ignore rxBit. On eopIn=1 with checkData=1: pulse packetDone with the latched error/crc flags, then go to IDLE.
REQ-027 If eopIn=1 in PID before the 8th bit, the block SHALL pulse packetDone with packetError=1 and go to IDLE.
REQ-028 If eopIn=1 in IDLE, the block SHALL clear the hunt register.
REQ-029 If eopIn and the 8th bit of a byte coincide, the bit is ignored and the EOP is handled.
REQ-030 checkData=0 cycles SHALL hold all state; pulse outputs are low on those cycles.
REQ-031 Latency: dataValid, pidValid and packetDone each assert on the edge that samples the completing bit or EOP, with no additional pipeline delay.
REQ-032 crcOk, packetError and byteCount SHALL hold their values until the next packet's PID state is entered. On PID entry, crcOk and packetError clear.

Reset
REQ-033 While resetN=0, the block SHALL asynchronously force:
  - state to IDLE;
  - hunt register and bit counter to 0;
  - CRC register to 16'hFFFF;
  - pidOut, dataByte and byteCount to 0;
  - pidValid, dataValid, packetDone, crcOk, packetError and busyRx to 0.
REQ-034 Reset asserted mid-packet SHALL discard the packet with no packetDone. After release, the block SHALL require a fresh SYNC.

Verification
REQ-035 SYNC, then PID 8'hC3, then bytes 80 06 00 01 00 00 40 00 DD 94, then EOP -> 10 dataValid pulses, byteCount=10, pidOut=4'h3, crcOk=1, packetError=0.
REQ-036 SYNC, then PID 8'h4B (DATA1), then bytes 00 00, then EOP -> byteCount=2, crcOk=1. Repeat with last byte 01 -> crcOk=0, packetError=1.
REQ-037 SYNC, then PID 8'hD2 (ACK), then EOP -> pidValid pulse, pidOut=4'h2, packetDone with crcOk=0, packetError=0, no dataValid.
REQ-038 SYNC, then PID 8'hC4 (check fail) -> no pidValid, packetDone with packetError=1 at EOP. Also: DATA0 of 67 bytes -> overflow error. Also: EOP after 3 bits of a byte -> packetError=1.
REQ-039 resetN pulsed low after 4 data bytes -> all outputs 0 immediately, no packetDone. A following valid DATA0 packet is received with crcOk=1.
REQ-040 checkData asserted every 4th useClk, with idle cycles between strobes -> results identical to REQ-035, and pulses never coincide with checkData=0.

Source files
------------

// File: rtl/usb_data_rx_if.sv
// ---------------------------------------------------------------------------
// usb_data_rx_if
// Bundles the bit-level inputs and the packet/byte results of the USB data
// receiver. The receiver is the slave (consumes line bits, produces results);
// whoever feeds it line bits is the master.
//
// Signals:
//   checkData   - one-cycle bit-time strobe, one per USB bit
//   rxBit       - NRZI-decoded, destuffed line bit (LSB-first)
//   eopIn       - high while SE0/EOP is on the bus
//   pidOut      - PID[3:0] of the last packet whose PID checked good
//   pidValid    - pulse when a PID passes its check
//   dataByte    - last assembled byte (CRC bytes included)
//   dataValid   - pulse per assembled byte
//   byteCount   - bytes in current DATA packet (CRC bytes included)
//   packetDone  - pulse at the end of any packet
//   crcOk       - with packetDone: DATA packet with good CRC16
//   packetError - with packetDone: PID fail, partial byte, overflow, bad CRC
//   busyRx      - receiver is somewhere other than IDLE
// ---------------------------------------------------------------------------
interface usb_data_rx_if;
    logic       checkData;
    logic       rxBit;
    logic       eopIn;
    logic [3:0] pidOut;
    logic       pidValid;
    logic [7:0] dataByte;
    logic       dataValid;
    logic [6:0] byteCount;
    logic       packetDone;
    logic       crcOk;
    logic       packetError;
    logic       busyRx;

    modport master (
        output checkData, rxBit, eopIn,
        input  pidOut, pidValid, dataByte, dataValid, byteCount,
        input  packetDone, crcOk, packetError, busyRx
    );

    modport slave (
        input  checkData, rxBit, eopIn,
        output pidOut, pidValid, dataByte, dataValid, byteCount,
        output packetDone, crcOk, packetError, busyRx
    );
endinterface

// File: rtl/usb_data_rx.sv
// ---------------------------------------------------------------------------
// usb_data_rx
// Bit-serial USB packet receiver. Hunts for SYNC, checks the PID, assembles
// DATA0/DATA1 payload bytes while running CRC16, and reports a per-packet
// result at EOP. All work happens only on checkData strobe cycles.
//
// Ports:
//   useClk  - system clock, rising edge
//   resetN  - asynchronous active-low reset
//   bus     - usb_data_rx_if.slave (line bits in, byte/packet results out)
// ---------------------------------------------------------------------------
module usb_data_rx (
    input  logic         useClk,
    input  logic         resetN,
    usb_data_rx_if.slave bus
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] PID      = 2'd1;
    localparam logic [1:0] DATA     = 2'd2;
    localparam logic [1:0] WAIT_EOP = 2'd3;

    localparam logic [7:0]  SYNC_PATTERN = 8'h80;
    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC_RESIDUAL = 16'hB001;
    localparam logic [6:0]  MAX_BYTES    = 7'd67;

    logic [1:0]  state;
    logic [7:0]  hunt;
    logic [2:0]  bitCnt;
    logic [7:0]  shiftReg;
    logic [15:0] crc;
    logic [3:0]  pidReg;
    logic        pidValidReg;
    logic [7:0]  dataByteReg;
    logic        dataValidReg;
    logic [6:0]  byteCountReg;
    logic        packetDoneReg;
    logic        crcOkReg;
    logic        packetErrorReg;

    logic [7:0]  huntNext;
    logic [7:0]  shiftNext;
    logic [15:0] crcNext;
    logic        crcFeedback;
    logic        pidCheckOk;
    logic        endOk;

    // Next-value helpers shared by the states: both shift registers take the
    // new bit at the MSB so a byte ends up LSB-first aligned after 8 bits,
    // and the CRC is the reflected CRC16 (poly 0xA001) stepped one bit.
    always_comb begin
        huntNext    = {bus.rxBit, hunt[7:1]};
        shiftNext   = {bus.rxBit, shiftReg[7:1]};
        crcFeedback = crc[0] ^ bus.rxBit;
        crcNext     = {1'b0, crc[15:1]} ^ (crcFeedback ? 16'hA001 : 16'h0000);
        pidCheckOk  = (shiftNext[3:0] == ~shiftNext[7:4]);
        endOk       = (crc == CRC_RESIDUAL) && (bitCnt == 3'd0) && (byteCountReg >= 7'd2);
    end

    // Main receive state machine. Pulses default low every cycle so they
    // are only ever high in the cycle after a strobed edge. An EOP always
    // wins over a bit arriving on the same strobe, so a byte or PID that
    // completes together with EOP is discarded.
    always_ff @(posedge useClk or negedge resetN) begin
        if (!resetN) begin
            state          <= IDLE;
            hunt           <= 8'h00;
            bitCnt         <= 3'd0;
            shiftReg       <= 8'h00;
            crc            <= CRC_INIT;
            pidReg         <= 4'h0;
            pidValidReg    <= 1'b0;
            dataByteReg    <= 8'h00;
            dataValidReg   <= 1'b0;
            byteCountReg   <= 7'd0;
            packetDoneReg  <= 1'b0;
            crcOkReg       <= 1'b0;
            packetErrorReg <= 1'b0;
        end else begin
            pidValidReg   <= 1'b0;
            dataValidReg  <= 1'b0;
            packetDoneReg <= 1'b0;
            if (bus.checkData) begin
                case (state)
                    IDLE: begin
                        if (bus.eopIn) begin
                            hunt <= 8'h00;
                        end else if (huntNext == SYNC_PATTERN) begin
                            // Hunt is cleared so the next packet needs its own SYNC.
                            hunt           <= 8'h00;
                            bitCnt         <= 3'd0;
                            crcOkReg       <= 1'b0;
                            packetErrorReg <= 1'b0;
                            state          <= PID;
                        end else begin
                            hunt <= huntNext;
                        end
                    end
                    PID: begin
                        if (bus.eopIn) begin
                            packetDoneReg  <= 1'b1;
                            packetErrorReg <= 1'b1;
                            crcOkReg       <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            shiftReg <= shiftNext;
                            bitCnt   <= bitCnt + 3'd1;
                            if (bitCnt == 3'd7) begin
                                if (!pidCheckOk) begin
                                    packetErrorReg <= 1'b1;
                                    state          <= WAIT_EOP;
                                end else begin
                                    pidReg      <= shiftNext[3:0];
                                    pidValidReg <= 1'b1;
                                    if (shiftNext[3:0] == 4'h3 || shiftNext[3:0] == 4'hB) begin
                                        byteCountReg <= 7'd0;
                                        crc          <= CRC_INIT;
                                        state        <= DATA;
                                    end else begin
                                        state <= WAIT_EOP;
                                    end
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (bus.eopIn) begin
                            crcOkReg       <= endOk;
                            packetErrorReg <= !endOk;
                            packetDoneReg  <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            crc      <= crcNext;
                            shiftReg <= shiftNext;
                            bitCnt   <= bitCnt + 3'd1;
                            if (bitCnt == 3'd7) begin
                                dataByteReg  <= shiftNext;
                                dataValidReg <= 1'b1;
                                if (byteCountReg < MAX_BYTES) begin
                                    byteCountReg <= byteCountReg + 7'd1;
                                end
                                // Byte 67 means more than 64 payload + 2 CRC bytes.
                                if (byteCountReg + 7'd1 >= MAX_BYTES) begin
                                    packetErrorReg <= 1'b1;
                                    state          <= WAIT_EOP;
                                end
                            end
                        end
                    end
                    WAIT_EOP: begin
                        if (bus.eopIn) begin
                            packetDoneReg <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.pidOut      = pidReg;
    assign bus.pidValid    = pidValidReg;
    assign bus.dataByte    = dataByteReg;
    assign bus.dataValid   = dataValidReg;
    assign bus.byteCount   = byteCountReg;
    assign bus.packetDone  = packetDoneReg;
    assign bus.crcOk       = crcOkReg;
    assign bus.packetError = packetErrorReg;
    assign bus.busyRx      = (state != IDLE);

endmodule

// File: tb/tb_usb_data_rx.sv
// ---------------------------------------------------------------------------
// tb_usb_data_rx
// Directed bench for usb_data_rx: a table of whole packets with hand-computed
// results, plus hand-written sequences for overflow, partial byte, EOP during
// PID, EOP on an 8th bit and reset in the middle of a packet.
// ---------------------------------------------------------------------------
module tb_usb_data_rx;

    logic useClk;
    logic resetN;

    usb_data_rx_if iface ();

    usb_data_rx dut (
        .useClk (useClk),
        .resetN (resetN),
        .bus    (iface.slave)
    );

    typedef struct {
        logic [7:0]        pid;
        int                nBytes;
        logic [0:11][7:0]  bytes;
        int                gap;
        int                expDv;
        int                expPv;
        logic [3:0]        expPid;
        logic [6:0]        expBc;
        logic [7:0]        expByte;
        logic              expCrcOk;
        logic              expErr;
    } vecT;

    vecT vecs [6];

    int assertCount = 0;
    int failCount   = 0;
    int gap         = 1;

    int pvCount   = 0;
    int dvCount   = 0;
    int pdCount   = 0;
    int pulseViol = 0;
    logic strobeSeen = 1'b0;

    // 10 ns clock.
    initial begin
        useClk = 1'b0;
        forever #5 useClk = ~useClk;
    end

    // Remember whether the edge just taken was a strobed one, then count the
    // pulses it produced half a cycle later; a pulse after an unstrobed edge
    // is a violation.
    always @(posedge useClk) strobeSeen = iface.checkData;

    always @(negedge useClk) begin
        if (iface.pidValid)   pvCount++;
        if (iface.dataValid)  dvCount++;
        if (iface.packetDone) pdCount++;
        if ((iface.pidValid || iface.dataValid || iface.packetDone) && !strobeSeen)
            pulseViol++;
    end

    // Compare one value and report a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearCounts();
        pvCount   = 0;
        dvCount   = 0;
        pdCount   = 0;
        pulseViol = 0;
    endtask

    // One strobed bit time followed by gap-1 idle clocks. Entered and left
    // 1 ns after a rising edge.
    task automatic strobe(input logic b, input logic e);
        iface.checkData = 1'b1;
        iface.rxBit     = b;
        iface.eopIn     = e;
        @(posedge useClk); #1;
        iface.checkData = 1'b0;
        iface.eopIn     = 1'b0;
        iface.rxBit     = 1'b0;
        repeat (gap - 1) begin
            @(posedge useClk); #1;
        end
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) strobe(v[i], 1'b0);
    endtask

    task automatic sendSync();
        for (int i = 0; i < 7; i++) strobe(1'b0, 1'b0);
        strobe(1'b1, 1'b0);
    endtask

    // Let the last pulse be counted before reading results.
    task automatic settle();
        @(negedge useClk); #1;
    endtask

    // Send one whole table packet: SYNC, PID, bytes, EOP; then compare.
    task automatic applyStimulus(input vecT v, input int idx);
        clearCounts();
        gap = v.gap;
        sendSync();
        sendByte(v.pid);
        for (int i = 0; i < v.nBytes; i++) sendByte(v.bytes[i]);
        strobe(1'b0, 1'b1);
        settle();
        checkOutput($sformatf("v%0d.pidValidCnt", idx),  pvCount, v.expPv);
        checkOutput($sformatf("v%0d.dataValidCnt", idx), dvCount, v.expDv);
        checkOutput($sformatf("v%0d.packetDoneCnt", idx), pdCount, 1);
        checkOutput($sformatf("v%0d.pidOut", idx),      iface.pidOut, v.expPid);
        checkOutput($sformatf("v%0d.byteCount", idx),   iface.byteCount, v.expBc);
        checkOutput($sformatf("v%0d.dataByte", idx),    iface.dataByte, v.expByte);
        checkOutput($sformatf("v%0d.crcOk", idx),       iface.crcOk, v.expCrcOk);
        checkOutput($sformatf("v%0d.packetError", idx), iface.packetError, v.expErr);
        checkOutput($sformatf("v%0d.busyRx", idx),      iface.busyRx, 1'b0);
        checkOutput($sformatf("v%0d.pulseViol", idx),   pulseViol, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".pidOut"},      iface.pidOut, 4'h0);
        checkOutput({tag, ".dataByte"},    iface.dataByte, 8'h00);
        checkOutput({tag, ".byteCount"},   iface.byteCount, 7'd0);
        checkOutput({tag, ".pulses"},      {iface.pidValid, iface.dataValid, iface.packetDone}, 3'b000);
        checkOutput({tag, ".crcOk"},       iface.crcOk, 1'b0);
        checkOutput({tag, ".packetError"}, iface.packetError, 1'b0);
        checkOutput({tag, ".busyRx"},      iface.busyRx, 1'b0);
    endtask

    logic [0:11][7:0] goodPkt;

    initial begin
        goodPkt = {8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94, 8'h00, 8'h00};

        //           pid    n   bytes                                    gap dv pv pid   bc     byte   ok    err
        vecs[0] = '{8'hC3, 10, goodPkt,                                   1, 10, 1, 4'h3, 7'd10, 8'h94, 1'b1, 1'b0};
        vecs[1] = '{8'h4B,  2, {8'h00, 8'h00, 80'h0},                     1,  2, 1, 4'hB, 7'd2,  8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h4B,  2, {8'h00, 8'h01, 80'h0},                     1,  2, 1, 4'hB, 7'd2,  8'h01, 1'b0, 1'b1};
        vecs[3] = '{8'hD2,  0, 96'h0,                                     1,  0, 1, 4'h2, 7'd2,  8'h01, 1'b0, 1'b0};
        vecs[4] = '{8'hC4,  0, 96'h0,                                     1,  0, 0, 4'h2, 7'd2,  8'h01, 1'b0, 1'b1};
        vecs[5] = '{8'hC3, 10, goodPkt,                                   4, 10, 1, 4'h3, 7'd10, 8'h94, 1'b1, 1'b0};

        iface.checkData = 1'b0;
        iface.rxBit     = 1'b0;
        iface.eopIn     = 1'b0;
        resetN          = 1'b0;

        repeat (3) @(posedge useClk);
        #1;
        checkAllZero("reset");
        resetN = 1'b1;
        @(posedge useClk); #1;

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], i);
        gap = 1;

        // DATA0 with 67 bytes: the 67th byte is an overflow.
        clearCounts();
        sendSync();
        sendByte(8'hC3);
        for (int i = 0; i < 67; i++) sendByte(8'h00);
        strobe(1'b0, 1'b1);
        settle();
        checkOutput("ovf.dataValidCnt", dvCount, 67);
        checkOutput("ovf.byteCount", iface.byteCount, 7'd67);
        checkOutput("ovf.packetDoneCnt", pdCount, 1);
        checkOutput("ovf.crcOk", iface.crcOk, 1'b0);
        checkOutput("ovf.packetError", iface.packetError, 1'b1);

        // Good CRC bytes, then EOP after 3 bits of a further byte.
        clearCounts();
        sendSync();
        sendByte(8'h4B);
        sendByte(8'h00);
        sendByte(8'h00);
        for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b1);
        settle();
        checkOutput("part.dataValidCnt", dvCount, 2);
        checkOutput("part.packetDoneCnt", pdCount, 1);
        checkOutput("part.crcOk", iface.crcOk, 1'b0);
        checkOutput("part.packetError", iface.packetError, 1'b1);

        // EOP arriving together with the 8th bit of a byte: the bit is dropped.
        clearCounts();
        sendSync();
        sendByte(8'h4B);
        sendByte(8'h00);
        sendByte(8'h00);
        for (int i = 0; i < 7; i++) strobe(1'b0, 1'b0);
        strobe(1'b0, 1'b1);
        settle();
        checkOutput("eop8.dataValidCnt", dvCount, 2);
        checkOutput("eop8.byteCount", iface.byteCount, 7'd2);
        checkOutput("eop8.packetError", iface.packetError, 1'b1);

        // EOP after 4 bits of the PID.
        clearCounts();
        sendSync();
        for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0);
        strobe(1'b0, 1'b1);
        settle();
        checkOutput("pideop.pidValidCnt", pvCount, 0);
        checkOutput("pideop.packetDoneCnt", pdCount, 1);
        checkOutput("pideop.packetError", iface.packetError, 1'b1);
        checkOutput("pideop.crcOk", iface.crcOk, 1'b0);
        checkOutput("pideop.busyRx", iface.busyRx, 1'b0);

        // Reset in the middle of a DATA0 packet after 4 bytes.
        clearCounts();
        sendSync();
        sendByte(8'hC3);
        for (int i = 0; i < 4; i++) sendByte(goodPkt[i]);
        checkOutput("rst.busyBefore", iface.busyRx, 1'b1);
        resetN = 1'b0;
        #1;
        checkAllZero("rst.async");
        repeat (2) @(posedge useClk);
        #1;
        resetN = 1'b1;
        settle();
        checkOutput("rst.packetDoneCnt", pdCount, 0);

        clearCounts();
        sendSync();
        sendByte(8'hC3);
        for (int i = 0; i < 10; i++) sendByte(goodPkt[i]);
        strobe(1'b0, 1'b1);
        settle();
        checkOutput("rst.after.dataValidCnt", dvCount, 10);
        checkOutput("rst.after.byteCount", iface.byteCount, 7'd10);
        checkOutput("rst.after.crcOk", iface.crcOk, 1'b1);
        checkOutput("rst.after.packetError", iface.packetError, 1'b0);
        checkOutput("rst.after.pulseViol", pulseViol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
